// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default geometry for the systolic array controller
package systolic_pkg;
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int RES_LAT = DEF_ROWS + DEF_COLS + 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: shifts a valid flag and payload forward DEPTH cycles, exposing early valid taps as a mask
module valid_delay_line #(
  parameter int DEPTH = 9,
  parameter int W = 8,
  parameter int NTAP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [W-1:0]    dat_i,
  output logic [NTAP-1:0] mask_o,
  output logic            vld_o,
  output logic [W-1:0]    dat_o
);
  logic [DEPTH:1]        vld_q;
  logic [DEPTH:1][W-1:0] dat_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-1:1], vld_i};
      dat_q <= {dat_q[DEPTH-1:1], dat_i};
    end
  end
  assign mask_o = vld_q[NTAP:1];
  assign vld_o = vld_q[DEPTH];
  assign dat_o = dat_q[DEPTH];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, activation streaming and result-row flagging for the systolic array
module systolic_ctrl import systolic_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int KW = 8,
  parameter int WAW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reuse_w,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [WAW-1:0]  w_rd_addr,
  output logic            weight_en,
  output logic            a_rd_en,
  output logic [KW-1:0]   a_rd_addr,
  output logic [ROWS-1:0] act_mask,
  output logic            res_valid,
  output logic [KW-1:0]   res_idx
);
  localparam int LAT = ROWS + COLS + 1;
  state_e state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d, k_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = !reuse_w ? LOAD_W : (k_len == '0 ? DONE : STREAM);
      end
      LOAD_W: begin
        cnt_d = cnt_q == KW'(ROWS) ? '0 : cnt_q + 1'b1;
        if (cnt_q == KW'(ROWS)) state_d = k_q == '0 ? DONE : STREAM;
      end
      STREAM: begin
        cnt_d = cnt_q == k_q - 1'b1 ? KW'(LAT) : cnt_q + 1'b1;
        if (cnt_q == k_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == KW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from next-state so they align with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      w_rd_en <= 1'b0;
      w_rd_addr <= '0;
      weight_en <= 1'b0;
      a_rd_en <= 1'b0;
      a_rd_addr <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && start) k_q <= k_len;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      w_rd_en <= state_d == LOAD_W && cnt_d < KW'(ROWS);
      w_rd_addr <= state_d == LOAD_W && cnt_d < KW'(ROWS) ? WAW'(ROWS - 1) - WAW'(cnt_d) : '0;
      weight_en <= state_d == LOAD_W && cnt_d != '0;
      a_rd_en <= state_d == STREAM;
      a_rd_addr <= state_d == STREAM ? cnt_d : '0;
    end
  end
  valid_delay_line #(.DEPTH(LAT), .W(KW), .NTAP(ROWS)) u_dly (
    .clk(clk),
    .rst(rst),
    .vld_i(a_rd_en),
    .dat_i(a_rd_addr),
    .mask_o(act_mask),
    .vld_o(res_valid),
    .dat_o(res_idx)
  );
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed bench recording each job's per-cycle outputs and checking hand-derived timelines
module tb_systolic_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, reuse_w = 1'b0;
  logic [7:0] k_len = '0;
  logic busy, done, w_rd_en, weight_en, a_rd_en, res_valid;
  logic [3:0] w_rd_addr, act_mask;
  logic [7:0] a_rd_addr, res_idx;
  int total = 0, passed = 0, fails = 0;
  logic t_busy[300], t_wen[300], t_we[300], t_aen[300], t_rv[300];
  logic [7:0] t_wad[300], t_aad[300], t_ri[300];
  logic [3:0] t_mask[300];
  int done_cyc, n_done, n_wen, n_we, n_aen, n_rv, bad;

  systolic_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .k_len(k_len),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .weight_en(weight_en), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .act_mask(act_mask), .res_valid(res_valid), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accepts a job at the first edge, then records outputs for cycles 1..done+1
  task automatic run_job(input int k, input bit ru, input int pa, input int pb, input bit hold);
    k_len = 8'(k);
    reuse_w = ru;
    start = 1'b1;
    done_cyc = -1;
    {n_done, n_wen, n_we, n_aen, n_rv} = '0;
    tick();
    start = 1'b0;
    k_len = 8'hAA;
    reuse_w = ~ru;
    for (int c = 1; c < 300; c++) begin
      t_busy[c] = busy; t_wen[c] = w_rd_en; t_wad[c] = 8'(w_rd_addr); t_we[c] = weight_en;
      t_aen[c] = a_rd_en; t_aad[c] = a_rd_addr; t_mask[c] = act_mask;
      t_rv[c] = res_valid; t_ri[c] = res_idx;
      n_wen += int'(w_rd_en); n_we += int'(weight_en); n_aen += int'(a_rd_en); n_rv += int'(res_valid);
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      start = (c == pa) || (c == pb) || (hold && done_cyc >= 0);
      tick();
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_outputs", {busy, done, w_rd_en, w_rd_addr, weight_en, a_rd_en, a_rd_addr, act_mask, res_valid, res_idx}, 0);
    rst = 1'b1;
    tick();
    chk("idle_outputs", {busy, done, w_rd_en, weight_en, a_rd_en, res_valid}, 0);

    run_job(3, 1'b0, 0, 0, 1'b0);
    chk("j1_busy_c1", t_busy[1], 1);
    for (int c = 1; c <= 4; c++) begin
      chk("j1_wen", t_wen[c], 1);
      chk("j1_waddr", t_wad[c], 4 - c);
    end
    chk("j1_wen_c5", t_wen[5], 0);
    chk("j1_we_c1", t_we[1], 0);
    chk("j1_we_c2", t_we[2], 1);
    chk("j1_we_c5", t_we[5], 1);
    chk("j1_we_c6", t_we[6], 0);
    chk("j1_we_count", n_we, 4);
    chk("j1_aen_c5", t_aen[5], 0);
    for (int i = 0; i < 3; i++) begin
      chk("j1_aen", t_aen[6 + i], 1);
      chk("j1_aaddr", t_aad[6 + i], i);
    end
    chk("j1_aen_c9", t_aen[9], 0);
    chk("j1_mask_c7", t_mask[7], 4'b0001);
    chk("j1_mask_c9", t_mask[9], 4'b0111);
    chk("j1_mask_c10", t_mask[10], 4'b1110);
    chk("j1_mask_c12", t_mask[12], 4'b1000);
    chk("j1_mask_c13", t_mask[13], 4'b0000);
    chk("j1_rv_c14", t_rv[14], 0);
    for (int i = 0; i < 3; i++) begin
      chk("j1_rv", t_rv[15 + i], 1);
      chk("j1_ridx", t_ri[15 + i], i);
    end
    chk("j1_rv_count", n_rv, 3);
    chk("j1_done_cyc", done_cyc, 18);
    chk("j1_done_count", n_done, 1);
    chk("j1_busy_done", t_busy[18], 1);
    chk("j1_busy_after", t_busy[19], 0);

    run_job(3, 1'b1, 0, 0, 1'b0);
    chk("j2_wen_count", n_wen, 0);
    chk("j2_we_count", n_we, 0);
    chk("j2_aen_c1", t_aen[1], 1);
    chk("j2_aaddr_c1", t_aad[1], 0);
    chk("j2_rv_c10", t_rv[10], 1);
    chk("j2_ridx_c12", t_ri[12], 2);
    chk("j2_rv_count", n_rv, 3);
    chk("j2_done_cyc", done_cyc, 13);

    run_job(0, 1'b0, 0, 0, 1'b0);
    chk("j3_wen_count", n_wen, 4);
    chk("j3_we_count", n_we, 4);
    chk("j3_aen_count", n_aen, 0);
    chk("j3_rv_count", n_rv, 0);
    chk("j3_done_cyc", done_cyc, 6);

    run_job(3, 1'b0, 7, 12, 1'b1);
    chk("j4a_done_cyc", done_cyc, 18);
    chk("j4a_done_count", n_done, 1);
    chk("j4a_idle_busy", t_busy[19], 0);
    run_job(3, 1'b0, 0, 0, 1'b0);
    chk("j4b_waddr_c1", t_wad[1], 3);
    chk("j4b_rv_c15", t_rv[15], 1);
    chk("j4b_ridx_c17", t_ri[17], 2);
    chk("j4b_rv_count", n_rv, 3);
    chk("j4b_done_cyc", done_cyc, 18);

    k_len = 8'd3;
    reuse_w = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("j5_streaming", {busy, a_rd_en}, 2'b11);
    rst = 1'b0;
    #2;
    chk("j5_rst_async", {busy, done, w_rd_en, w_rd_addr, weight_en, a_rd_en, a_rd_addr, act_mask, res_valid, res_idx}, 0);
    tick();
    chk("j5_rst_held", {busy, done, w_rd_en, w_rd_addr, weight_en, a_rd_en, a_rd_addr, act_mask, res_valid, res_idx}, 0);
    rst = 1'b1;
    tick();
    run_job(3, 1'b1, 0, 0, 1'b0);
    chk("j6_rv_count", n_rv, 3);
    chk("j6_rv_c10", t_rv[10], 1);
    chk("j6_ridx_c10", t_ri[10], 0);
    chk("j6_done_cyc", done_cyc, 13);

    run_job(255, 1'b1, 0, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 255; i++)
      if (t_rv[10 + i] !== 1'b1 || t_ri[10 + i] !== 8'(i)) bad++;
    chk("j7_seq_errors", bad, 0);
    chk("j7_rv_count", n_rv, 255);
    chk("j7_aen_count", n_aen, 255);
    chk("j7_done_count", n_done, 1);
    chk("j7_done_cyc", done_cyc, 265);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the weight-stationary systolic array built from the team's Q6.10 PE tiles. On a `start` request it loads one weight tile into the array via the PE weight-enable chain. It then streams `k_len` activation vectors from the activation buffer, generates per-row skew masks, and flags when each de-skewed result row leaves the bottom of the array. It sits between the top-level command interface and the array and its weight, activation and result buffers.

## Interface
Parameters:
- `ROWS`, 4, PE rows; weight-chain depth and activation lanes.
- `COLS`, 4, PE columns.
- `KW`, 8, width of vector count and indices.
- `WAW`, 4, weight buffer address width; must satisfy `2**WAW >= ROWS`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: job request; accepted only in IDLE.
- `reuse_w`, in, 1: sampled with `start`; 1 skips weight load.
- `k_len`, in, KW: number of activation vectors; sampled with `start`.
- `busy`, out, 1: job in progress.
- `done`, out, 1: one-cycle completion pulse.
- `w_rd_en`, out, 1: weight buffer read; 1-cycle read latency.
- `w_rd_addr`, out, WAW: weight row address.
- `weight_en`, out, 1: broadcast to every PE weight enable.
- `a_rd_en`, out, 1: activation buffer read; 1-cycle read latency.
- `a_rd_addr`, out, KW: activation vector index.
- `act_mask`, out, ROWS: bit r high when row r array input carries valid data. External logic zeroes the lane when the bit is low.
- `res_valid`, out, 1: de-skewed result row valid.
- `res_idx`, out, KW: vector index of current result row.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE. Encoding lives in the shared package.
- IDLE → LOAD_W on `start & !reuse_w`; IDLE → STREAM on `start & reuse_w`. If `k_len == 0`, go → DONE instead of STREAM.
- LOAD_W runs for `ROWS+1` cycles, j = 0..ROWS:
  - `w_rd_en=1` and `w_rd_addr = ROWS-1-j` for j < ROWS.
  - `weight_en=1` for j = 1..ROWS, so the bottom row is shifted in first.
- LOAD_W → STREAM, or → DONE if `k_len == 0`.
- STREAM runs for `k_len` cycles: `a_rd_en=1`, `a_rd_addr` counts 0..k_len-1, then → DRAIN.
- DRAIN holds until the last `res_valid` has been issued, then → DONE.
- DONE lasts one cycle with `done=1`, then → IDLE.
- `weight_en` is 0 outside LOAD_W. Weights stay stationary through STREAM and DRAIN.
- `start` outside IDLE is ignored. `k_len` and `reuse_w` are latched at acceptance; later changes have no effect.
- Reset, asynchronous at any time including mid-job: state=IDLE. All outputs go to 0: `busy`, `done`, enables, addresses, `act_mask`, `res_valid`, `res_idx`. The delay line clears.
- Index counters are KW bits. `k_len = 2**KW-1` must run to completion without wrap.

## Timing
- Let s0 be the first STREAM cycle.
- `busy`:
  - Rises the cycle after `start` is accepted.
  - Stays high through the DONE cycle.
  - Falls when `done` falls.
- Row r array-input cycles are s0+1+r+i for i = 0..k_len-1. This reflects 1 cycle of buffer latency plus r cycles of external skew registers. `act_mask[r]` is high exactly over those cycles.
- With the PE pipeline, bottom column c for vector i appears at array-input cycle T_i + ROWS + c + 1, where T_i = s0+1+i.
- External de-skew delays column c by COLS-1-c cycles.
- `res_valid` for vector i is high at cycle s0+1+i+ROWS+COLS, with `res_idx = i`.
- Last `res_valid` is at s0+k_len+ROWS+COLS. `done` follows in the next cycle.
- Total job latency from `start`:
  - Without reuse: 1 + (ROWS+1) + k_len + ROWS + COLS + 1 cycles to `done`.
  - With `reuse_w`: ROWS+1 fewer.
- Back-to-back: `start` may be high in the cycle `done` is high, but it is not accepted. It is accepted from the first IDLE cycle onward.

## Structure
- Package `systolic_pkg`:
  - State enum.
  - `ROWS`/`COLS` defaults.
  - Localparam `RES_LAT = ROWS+COLS+1`, the delay from `a_rd_en` to `res_valid`.
- Sub-module `valid_delay_line`, parameterised by depth and width:
  - Carries `{a_rd_en, a_rd_addr}` forward RES_LAT cycles to produce `res_valid`/`res_idx`.
  - Its taps 1..ROWS form `act_mask`: tap 1+r gives bit r.
  - Asynchronous active-low clear.
- DRAIN exit uses a down-counter loaded with RES_LAT on STREAM exit.

## Test plan
- ROWS=COLS=4, `k_len=3`, `reuse_w=0`:
  - `w_rd_addr` 3,2,1,0 on cycles 1–4 after accept.
  - `weight_en` high on cycles 2–5.
  - `a_rd_addr` 0,1,2.
  - `act_mask[3]` high at s0+4..s0+6.
  - `res_valid` at s0+9..s0+11 with `res_idx` 0,1,2.
  - `done` at s0+12.
- Same job with `reuse_w=1`: no `w_rd_en`/`weight_en`; s0 is the cycle after accept; `done` 5 cycles earlier than the first case.
- `k_len=0`, `reuse_w=0`: weight load occurs, no `a_rd_en`, no `res_valid`, `done` right after LOAD_W.
- `start` pulsed during STREAM and again during DONE: ignored. A held `start` is accepted in the first IDLE cycle, and the second job's timeline is identical to the first.
- `rst` low in mid-STREAM (cycle s0+1): next cycle all outputs are 0 and the state is IDLE. A new job after release runs with no stale `res_valid`.
- `k_len=255`, KW=8: 255 consecutive `res_idx` 0..254 with no wrap or gap; `done` once.
